sliding_window_ctrl: RTL and testbench
======================================

// Module: sliding_window_ctrl
// PURPOSE
//  Sequences one frame of raster pixels into a KxK sliding-window datapath.
//  Accepts pixels over valid/ready and drives the window's shift enable.
//  Tracks column/row position and flags only windows that lie fully inside the frame.
//  Sits between the pixel source and the window/kernel stage, and applies downstream backpressure.
// PARAMETERS
//  KERNEL_SIZE  3    window edge K (>=2, <=ROW_WIDTH, <=NUM_ROWS)
//  ROW_WIDTH    640  pixels per row
//  NUM_ROWS     480  rows per frame
//  WORD_SIZE    8    signed pixel width
// PORTS
//  clk         in   1              single clock, rising edge
//  reset       in   1              asynchronous, active-high
//  start       in   1              1-cycle pulse, arms a frame (ignored unless IDLE)
//  in_valid    in   1              pixel_in valid
//  in_ready    out  1              controller accepts pixel_in this cycle
//  pixel_in    in   WORD_SIZE      signed raster pixel
//  shift_en    out  1              = in_valid & in_ready; window shifts this cycle
//  pixel_out   out  WORD_SIZE      = pixel_in, combinational pass to the window
//  out_ready   in   1              downstream consumed the current window
//  win_valid   out  1              window buffer holds a full in-frame KxK window
//  win_col     out  $clog2(ROW_WIDTH)  column of the window's bottom-right pixel
//  win_row     out  $clog2(NUM_ROWS)   row of the window's bottom-right pixel
//  busy        out  1              state != IDLE
//  frame_done  out  1              1-cycle pulse, last window consumed
// BEHAVIOUR
//  Reset: state=IDLE; col=0, row=0; win_valid=0, win_col=0, win_row=0, frame_done=0.
//   Reset is asynchronous, so it may occur mid-frame; the partial frame is discarded.
//  States:
//   IDLE: in_ready=0. start moves to PRIME and clears col/row.
//   PRIME: rows 0..K-2; pixels are accepted, no win_valid. Moves to ACTIVE on the accept of (K-2, ROW_WIDTH-1).
//   ACTIVE: rows K-1..NUM_ROWS-1. Moves to DRAIN on the accept of (NUM_ROWS-1, ROW_WIDTH-1).
//   DRAIN: in_ready=0. Waits for the final win_valid&out_ready, then pulses frame_done and goes to IDLE.
//  in_ready = (PRIME|ACTIVE) & (!win_valid | out_ready).
//   A window never overwrites an unconsumed one.
//  On each accept (shift_en):
//   col increments. At col==ROW_WIDTH-1, col wraps to 0 and row increments.
//  Latency 1: win_valid is registered one cycle after accepting pixel (r,c) with r>=K-1 and c>=K-1.
//   This matches the window update edge. win_col/win_row are set to (c,r).
//  Hold: win_valid and its coordinates hold until out_ready.
//   out_ready without a new qualifying accept clears win_valid.
//   out_ready together with a new qualifying accept keeps win_valid=1 and loads the new coordinates.
//  Columns 0..K-2 of every row shift the window (row-edge straddle) but never assert win_valid.
//  Windows per frame = (ROW_WIDTH-K+1)*(NUM_ROWS-K+1), exactly.
//  start while busy is ignored. in_valid in IDLE/DRAIN is not accepted.
//  Counter widths come from $clog2. No counter wraps beyond ROW_WIDTH-1 / NUM_ROWS-1.
// CONFIGURATION
//  SLIDING_WINDOW_CTRL_STALL_CNT_EN defined:
//   adds output stall_cnt [31:0], which counts cycles with in_valid & !in_ready while busy.
//   stall_cnt clears on start and on reset, and saturates at 2^32-1.
//  SLIDING_WINDOW_CTRL_STALL_CNT_EN undefined: no port and no logic.
// STRUCTURE
//  Package sliding_window_pkg:
//   ctrl_state_t enum {IDLE, PRIME, ACTIVE, DRAIN};
//   localparam widths COL_W and ROW_W as functions of the parameters.
//  Sub-module pixel_coord_counter:
//   col/row raster counter with advance, clear, last_col and last_pixel outputs.
//  FSM and the window-valid register live in sliding_window_ctrl.
// TESTING (K=3, ROW_WIDTH=5, NUM_ROWS=4 unless noted)
//  1. start, then 20 pixels streamed with out_ready=1:
//     exactly 6 win_valid cycles.
//     First window one cycle after pixel #13 (r2,c2). Coordinates are (2,2),(3,2),(4,2),(2,3),(3,3),(4,3).
//     frame_done one cycle after the last window.
//  2. out_ready=0 for 5 cycles at the first window:
//     in_ready=0, shift_en=0, and win_valid/win_col/win_row are stable.
//     Release resumes with no lost or duplicated windows (still 6 total).
//  3. in_valid toggled randomly (50%):
//     same 6 coordinates in order, and shift_en count = 20.
//  4. start pulsed mid-frame:
//     ignored, and busy stays 1.
//     reset asserted mid-ACTIVE: next clk sees IDLE, win_valid=0, in_ready=0. A new start gives 6 windows.
//  5. K=5, ROW_WIDTH=10, NUM_ROWS=6:
//     12 windows, with first coordinate (4,4) and last (9,5).
//  6. With SLIDING_WINDOW_CTRL_STALL_CNT_EN, scenario 2:
//     stall_cnt = 5 (in_valid held 1). stall_cnt=0 after the next start.

Source files
------------

// File: rtl/sliding_window_pkg.sv
// Shared types and width helpers for the sliding-window controller.
package sliding_window_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DRAIN} ctrl_state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ROW_WIDTH = 640;
    localparam int DEF_NUM_ROWS  = 480;
    localparam int COL_W = cnt_w(DEF_ROW_WIDTH);
    localparam int ROW_W = cnt_w(DEF_NUM_ROWS);

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster column/row counter; wraps to (0,0) after the last pixel of the frame.
module pixel_coord_counter
    import sliding_window_pkg::*;
#(
    parameter int ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int NUM_ROWS  = DEF_NUM_ROWS,
    localparam int CW = cnt_w(ROW_WIDTH),
    localparam int RW = cnt_w(NUM_ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_pixel
);

    assign last_col   = (col == CW'(ROW_WIDTH - 1));
    assign last_pixel = last_col && (row == RW'(NUM_ROWS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_pixel ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sliding_window_ctrl.sv
// Frame sequencer for a KxK sliding window: accepts raster pixels, flags in-frame windows.
// Optional SLIDING_WINDOW_CTRL_STALL_CNT_EN adds a saturating input-stall counter output.
module sliding_window_ctrl
    import sliding_window_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_WIDTH   = DEF_ROW_WIDTH,
    parameter int NUM_ROWS    = DEF_NUM_ROWS,
    parameter int WORD_SIZE   = 8,
    localparam int CW = cnt_w(ROW_WIDTH),
    localparam int RW = cnt_w(NUM_ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] pixel_in,
    output logic                 shift_en,
    output logic [WORD_SIZE-1:0] pixel_out,
    input  logic                 out_ready,
    output logic                 win_valid,
    output logic [CW-1:0]        win_col,
    output logic [RW-1:0]        win_row,
    output logic                 busy,
    output logic                 frame_done
`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    ctrl_state_t   state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col, last_pixel, clear, in_win, frame_done_nxt;

    pixel_coord_counter #(
        .ROW_WIDTH (ROW_WIDTH),
        .NUM_ROWS  (NUM_ROWS)
    ) u_coord (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .advance    (shift_en),
        .col        (col),
        .row        (row),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    // A pending window blocks input unless it is being consumed this cycle.
    assign in_ready  = ((state == PRIME) || (state == ACTIVE)) && (!win_valid || out_ready);
    assign shift_en  = in_valid && in_ready;
    assign pixel_out = pixel_in;
    assign busy      = (state != IDLE);
    assign clear     = (state == IDLE) && start;
    assign in_win    = shift_en && (row >= RW'(KERNEL_SIZE - 1)) && (col >= CW'(KERNEL_SIZE - 1));

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = PRIME;
            PRIME:  if (shift_en && last_col && (row == RW'(KERNEL_SIZE - 2))) state_nxt = ACTIVE;
            ACTIVE: if (shift_en && last_pixel) state_nxt = DRAIN;
            DRAIN: begin
                if (win_valid && out_ready) begin
                    state_nxt      = IDLE;
                    frame_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
            if (in_win) begin
                win_valid <= 1'b1;
                win_col   <= col;
                win_row   <= row;
            end else if (out_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (clear)
            stall_cnt <= '0;
        else if (busy && in_valid && !in_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// Randomized bench for sliding_window_ctrl against a raster-order window list model.
module tb_sliding_window_ctrl;

    localparam int K  = 3, W  = 5,  N  = 4;
    localparam int K2 = 5, W2 = 10, N2 = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] pixel_in = '0;
    logic       in_ready, shift_en, win_valid, busy, frame_done;
    logic [7:0] pixel_out;
    logic [2:0] win_col;
    logic [1:0] win_row;
`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic       b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic [7:0] b_pixel_in = '0;
    logic       b_in_ready, b_shift_en, b_win_valid, b_busy, b_frame_done;
    logic [7:0] b_pixel_out;
    logic [3:0] b_win_col;
    logic [2:0] b_win_row;
`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
    logic [31:0] b_stall_cnt;
`endif

    sliding_window_ctrl #(.KERNEL_SIZE(K), .ROW_WIDTH(W), .NUM_ROWS(N), .WORD_SIZE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_in(pixel_in), .shift_en(shift_en), .pixel_out(pixel_out), .out_ready(out_ready),
        .win_valid(win_valid), .win_col(win_col), .win_row(win_row), .busy(busy),
        .frame_done(frame_done)
`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    sliding_window_ctrl #(.KERNEL_SIZE(K2), .ROW_WIDTH(W2), .NUM_ROWS(N2), .WORD_SIZE(8)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pixel_in(b_pixel_in), .shift_en(b_shift_en), .pixel_out(b_pixel_out), .out_ready(b_out_ready),
        .win_valid(b_win_valid), .win_col(b_win_col), .win_row(b_win_row), .busy(b_busy),
        .frame_done(b_frame_done)
`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    int checks = 0, errors = 0;

    // Observed windows (consumed handshakes) and event times
    int  got_c[$], got_r[$], b_got_c[$], b_got_r[$];
    int  exp_c[$], exp_r[$];
    int  shift_cnt = 0, done_cnt = 0;
    time first_hs_t = 0, last_hs_t = 0, done_t = 0, acc13_t = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (win_valid && out_ready) begin
                if (got_c.size() == 0) first_hs_t = $time;
                got_c.push_back(int'(win_col));
                got_r.push_back(int'(win_row));
                last_hs_t = $time;
            end
            if (shift_en) shift_cnt++;
            if (frame_done) begin
                done_cnt++;
                done_t = $time;
            end
            if (b_win_valid && b_out_ready) begin
                b_got_c.push_back(int'(b_win_col));
                b_got_r.push_back(int'(b_win_row));
            end
        end
    end

    // Reference: every bottom-right corner that fits a full KxK window, raster order
    task automatic build_exp(input int k, input int w, input int n);
        exp_c.delete();
        exp_r.delete();
        for (int r = k - 1; r < n; r++)
            for (int c = k - 1; c < w; c++) begin
                exp_c.push_back(c);
                exp_r.push_back(r);
            end
    endtask

    function automatic int diff_cnt(input int gc[$], input int gr[$], input int ec[$], input int er[$]);
        int d = (gc.size() > ec.size()) ? gc.size() - ec.size() : ec.size() - gc.size();
        for (int i = 0; i < gc.size() && i < ec.size(); i++)
            if (gc[i] != ec[i] || gr[i] != er[i]) d++;
        return d;
    endfunction

    task automatic clear_mon();
        got_c.delete();
        got_r.delete();
        shift_cnt = 0;
        done_cnt  = 0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Streams until n pixels are accepted; optional 5-cycle backpressure at the first window.
    task automatic stream_pixels(input int n, input int vpct, input int rpct, input bit hold_first);
        int  sent = 0, guard = 0;
        bit  held = 0;
        logic [2:0] hc;
        logic [1:0] hr;
        while (sent < n && guard < 1000) begin
            guard++;
            if (hold_first && !held && win_valid) begin
                held = 1;
                hc = win_col;
                hr = win_row;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || shift_en !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_ready: in_ready=%b shift_en=%b, want 0/0", in_ready, shift_en);
                    end
                    checks++;
                    if (win_valid !== 1'b1 || win_col !== hc || win_row !== hr) begin
                        errors++;
                        $display("FAIL hold_window: v=%b (%0d,%0d), want 1 (%0d,%0d)", win_valid, win_col, win_row, hc, hr);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            in_valid  = ($urandom_range(0, 99) < vpct);
            out_ready = ($urandom_range(0, 99) < rpct);
            pixel_in  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (pixel_out !== pixel_in) begin
                errors++;
                $display("FAIL pixel_pass: got %h, want %h", pixel_out, pixel_in);
            end
            if (shift_en) begin
                if (sent == 12) acc13_t = $time;
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d, want %0d", sent, n);
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        out_ready = 1'b1;
        while (done_cnt == 0 && guard < 50) begin
            guard++;
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d, want 1", done_cnt);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy !== 1'b0 || win_valid !== 1'b0 || win_col !== 3'd0 || win_row !== 2'd0 ||
            frame_done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b wv=%b col=%0d row=%0d fd=%b rdy=%b, want all 0",
                     busy, win_valid, win_col, win_row, frame_done, in_ready);
        end
        @(posedge clk); #2 reset = 1'b0;
    endtask

    task automatic test_stream();
        clear_mon();
        start_frame();
        stream_pixels(20, 100, 100, 0);
        wait_done();
        checks++;
        if (diff_cnt(got_c, got_r, exp_c, exp_r) != 0) begin
            errors++;
            $display("FAIL stream_windows: got %0d windows, want %0d in raster order", got_c.size(), exp_c.size());
        end
        checks++;
        if (first_hs_t - acc13_t != 10) begin
            errors++;
            $display("FAIL first_latency: got %0t, want 10", first_hs_t - acc13_t);
        end
        checks++;
        if (done_t - last_hs_t != 10) begin
            errors++;
            $display("FAIL done_latency: got %0t, want 10", done_t - last_hs_t);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_frame: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_stall();
        clear_mon();
        start_frame();
        stream_pixels(20, 100, 100, 1);
        wait_done();
        checks++;
        if (diff_cnt(got_c, got_r, exp_c, exp_r) != 0) begin
            errors++;
            $display("FAIL stall_windows: got %0d windows, want %0d", got_c.size(), exp_c.size());
        end
`ifdef SLIDING_WINDOW_CTRL_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, want 5", stall_cnt);
        end
        clear_mon();
        start_frame();
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_clear: got %0d, want 0", stall_cnt);
        end
        stream_pixels(20, 100, 100, 0);
        wait_done();
`endif
    endtask

    task automatic test_random_valid(input int rpct);
        clear_mon();
        start_frame();
        stream_pixels(20, 50, rpct, 0);
        wait_done();
        checks++;
        if (diff_cnt(got_c, got_r, exp_c, exp_r) != 0) begin
            errors++;
            $display("FAIL random_windows(rdy=%0d): got %0d windows, want %0d", rpct, got_c.size(), exp_c.size());
        end
        checks++;
        if (shift_cnt != 20) begin
            errors++;
            $display("FAIL random_shift_count: got %0d, want 20", shift_cnt);
        end
    endtask

    task automatic test_start_ignored();
        clear_mon();
        start_frame();
        stream_pixels(8, 100, 100, 0);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b, want 1", busy);
        end
        @(posedge clk); #1 start = 1'b0;
        stream_pixels(12, 100, 100, 0);
        wait_done();
        checks++;
        if (diff_cnt(got_c, got_r, exp_c, exp_r) != 0 || shift_cnt != 20) begin
            errors++;
            $display("FAIL start_ignored_frame: windows=%0d shifts=%0d, want %0d/20", got_c.size(), shift_cnt, exp_c.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        start_frame();
        stream_pixels(13, 100, 100, 0);
        in_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || win_valid !== 1'b0 || in_ready !== 1'b0 || shift_en !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b wv=%b rdy=%b sh=%b, want 0", busy, win_valid, in_ready, shift_en);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || win_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_clk: busy=%b wv=%b rdy=%b, want 0", busy, win_valid, in_ready);
        end
        @(posedge clk); #2 reset = 1'b0;
        in_valid = 1'b0;
        clear_mon();
        start_frame();
        stream_pixels(20, 100, 100, 0);
        wait_done();
        checks++;
        if (diff_cnt(got_c, got_r, exp_c, exp_r) != 0) begin
            errors++;
            $display("FAIL post_reset_windows: got %0d, want %0d", got_c.size(), exp_c.size());
        end
    endtask

    task automatic test_k5();
        int sent = 0, guard = 0;
        b_got_c.delete();
        b_got_r.delete();
        build_exp(K2, W2, N2);
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        while (sent < W2 * N2 && guard < 2000) begin
            guard++;
            b_in_valid  = ($urandom_range(0, 99) < 70);
            b_out_ready = ($urandom_range(0, 99) < 70);
            b_pixel_in  = 8'($urandom);
            @(negedge clk);
            if (b_shift_en) sent++;
            @(posedge clk); #1;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sent != W2 * N2 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL k5_complete: accepted %0d busy=%b, want %0d/0", sent, b_busy, W2 * N2);
        end
        checks++;
        if (b_got_c.size() != 12) begin
            errors++;
            $display("FAIL k5_count: got %0d, want 12", b_got_c.size());
        end else begin
            checks++;
            if (b_got_c[0] != 4 || b_got_r[0] != 4 || b_got_c[11] != 9 || b_got_r[11] != 5) begin
                errors++;
                $display("FAIL k5_ends: first (%0d,%0d) last (%0d,%0d), want (4,4) (9,5)",
                         b_got_c[0], b_got_r[0], b_got_c[11], b_got_r[11]);
            end
        end
        checks++;
        if (diff_cnt(b_got_c, b_got_r, exp_c, exp_r) != 0) begin
            errors++;
            $display("FAIL k5_windows: list differs from raster model");
        end
        build_exp(K, W, N);
    endtask

    initial begin
        build_exp(K, W, N);
        test_reset();
        test_stream();
        test_stall();
        test_random_valid(100);
        test_random_valid(60);
        test_start_ignored();
        test_reset_mid();
        test_k5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
